attn_job_loader: RTL and testbench



---
 rtl/attn_pkg.sv | 26 ++
 rtl/attn_job_loader_if.sv | 16 +
 rtl/attn_job_loader_sram_write_seq.sv | 67 ++++++
 rtl/attn_job_loader.sv | 131 +++++++++++++
 tb/tb_attn_job_loader.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/attn_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | attn_pkg: shared types and header field constants for the loader  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package attn_pkg;

   localparam int NUM_WMAT_DEFAULT = 3;

   localparam int HDR_ROWS_MSB = 31;
   localparam int HDR_ROWS_LSB = 16;
   localparam int HDR_COLS_MSB = 15;
   localparam int HDR_COLS_LSB = 0;

   typedef enum logic [2:0] {
      ST_IN_HDR    = 3'd0,
      ST_IN_DATA   = 3'd1,
      ST_W_HDR     = 3'd2,
      ST_W_DATA    = 3'd3,
      ST_KICK      = 3'd4,
      ST_WAIT_BUSY = 3'd5,
      ST_WAIT_DONE = 3'd6
   } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/attn_job_loader_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | attn_job_loader_if: valid/ready job word stream                   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface attn_job_loader_if #(
   parameter int DATA_W = 32
) ();
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface
`default_nettype wire

// File: rtl/attn_job_loader_sram_write_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sram_write_seq: registered SRAM write port with element counter   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module sram_write_seq #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  wire logic              clk,
   input  wire logic              reset,
   input  wire logic              hdr_accept,
   input  wire logic              elem_accept,
   input  wire logic [DATA_W-1:0] data,
   input  wire logic [31:0]       total,
   output logic                   wr_en,
   output logic [ADDR_W-1:0]      wr_addr,
   output logic [DATA_W-1:0]      wr_data,
   output logic                   last,
   output logic                   ovf
);
   localparam logic [32:0] ADDR_LIMIT = 33'd1 << ADDR_W;

   logic [31:0]       r_total;
   logic [31:0]       r_next;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              w_in_range;

   // r_next is the 1-based index of the element about to be accepted
   assign w_in_range = ({1'b0, r_next} < ADDR_LIMIT);
   assign ovf        = (({1'b0, total} + 33'd1) > ADDR_LIMIT);
   assign last       = (r_next == r_total);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_total <= '0;
         r_next  <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else begin
         r_we <= 1'b0;
         if (hdr_accept) begin
            r_total <= total;
            r_next  <= 32'd1;
            r_we    <= 1'b1;
            r_addr  <= '0;
            r_data  <= data;
         end else if (elem_accept) begin
            r_next <= r_next + 32'd1;
            // Out-of-range elements are consumed but never written; no wrap
            if (w_in_range) begin
               r_we   <= 1'b1;
               r_addr <= r_next[ADDR_W-1:0];
               r_data <= data;
            end
         end
      end
   end

   assign wr_en   = r_we;
   assign wr_addr = r_addr;
   assign wr_data = r_data;
endmodule
`default_nettype wire

// File: rtl/attn_job_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | attn_job_loader: job stream -> input/weight SRAM, then kick compute|
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module attn_job_loader
   import attn_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 32,
   parameter int NUM_WMAT = NUM_WMAT_DEFAULT
) (
   input  wire logic         clk,
   input  wire logic         reset,
   attn_job_loader_if.slave  s,
   output logic              job_busy,
   output logic              job_done,
   output logic              job_err,
   output logic              dut_valid,
   input  wire logic         dut_ready,
   output logic              sram_input_write_enable,
   output logic [ADDR_W-1:0] sram_input_write_address,
   output logic [DATA_W-1:0] sram_input_write_data,
   output logic              sram_weight_write_enable,
   output logic [ADDR_W-1:0] sram_weight_write_address,
   output logic [DATA_W-1:0] sram_weight_write_data
);
   loader_state_e r_state, w_state_nxt;

   logic        w_s_ready, w_acc;
   logic        w_in_hdr_acc, w_in_elem_acc, w_w_hdr_acc, w_w_elem_acc;
   logic [15:0] w_rows, w_cols;
   logic [31:0] w_in_total, w_wt_total;
   logic        w_in_last, w_w_last, w_in_ovf, w_w_ovf;
   logic        w_dut_valid_nxt, w_job_done_nxt;
   logic        r_dut_valid, r_job_done, r_job_busy, r_job_err;

   assign w_rows     = s.s_data[HDR_ROWS_MSB:HDR_ROWS_LSB];
   assign w_cols     = s.s_data[HDR_COLS_MSB:HDR_COLS_LSB];
   assign w_in_total = 32'(w_rows) * 32'(w_cols);
   assign w_wt_total = 32'(NUM_WMAT) * w_in_total;

   assign w_acc         = s.s_valid && w_s_ready;
   assign w_in_hdr_acc  = w_acc && (r_state == ST_IN_HDR);
   assign w_in_elem_acc = w_acc && (r_state == ST_IN_DATA);
   assign w_w_hdr_acc   = w_acc && (r_state == ST_W_HDR);
   assign w_w_elem_acc  = w_acc && (r_state == ST_W_DATA);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IN_HDR;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IN_HDR:    if (w_acc) w_state_nxt = (w_in_total == 32'd0) ? ST_W_HDR : ST_IN_DATA;
         ST_IN_DATA:   if (w_acc && w_in_last) w_state_nxt = ST_W_HDR;
         ST_W_HDR:     if (w_acc) w_state_nxt = (w_wt_total == 32'd0) ? ST_KICK : ST_W_DATA;
         ST_W_DATA:    if (w_acc && w_w_last) w_state_nxt = ST_KICK;
         ST_KICK:      if (dut_ready) w_state_nxt = ST_WAIT_BUSY;
         ST_WAIT_BUSY: if (!dut_ready) w_state_nxt = ST_WAIT_DONE;
         ST_WAIT_DONE: if (dut_ready) w_state_nxt = ST_IN_HDR;
         default:      w_state_nxt = ST_IN_HDR;
      endcase
   end

   always_comb begin
      w_s_ready       = 1'b0;
      w_dut_valid_nxt = 1'b0;
      w_job_done_nxt  = 1'b0;
      case (r_state)
         ST_IN_HDR, ST_IN_DATA, ST_W_HDR, ST_W_DATA: w_s_ready = 1'b1;
         ST_KICK:      w_dut_valid_nxt = dut_ready;
         ST_WAIT_DONE: w_job_done_nxt  = dut_ready;
         default:      ;
      endcase
   end

   // job_err clears only on an input header; a weight overflow can only set it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dut_valid <= 1'b0;
         r_job_done  <= 1'b0;
         r_job_busy  <= 1'b0;
         r_job_err   <= 1'b0;
      end else begin
         r_dut_valid <= w_dut_valid_nxt;
         r_job_done  <= w_job_done_nxt;
         if (w_in_hdr_acc)        r_job_busy <= 1'b1;
         else if (w_job_done_nxt) r_job_busy <= 1'b0;
         if (w_in_hdr_acc)                r_job_err <= w_in_ovf;
         else if (w_w_hdr_acc && w_w_ovf) r_job_err <= 1'b1;
      end
   end

   sram_write_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_in_seq (
      .clk         (clk),
      .reset       (reset),
      .hdr_accept  (w_in_hdr_acc),
      .elem_accept (w_in_elem_acc),
      .data        (s.s_data),
      .total       (w_in_total),
      .wr_en       (sram_input_write_enable),
      .wr_addr     (sram_input_write_address),
      .wr_data     (sram_input_write_data),
      .last        (w_in_last),
      .ovf         (w_in_ovf)
   );

   sram_write_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wt_seq (
      .clk         (clk),
      .reset       (reset),
      .hdr_accept  (w_w_hdr_acc),
      .elem_accept (w_w_elem_acc),
      .data        (s.s_data),
      .total       (w_wt_total),
      .wr_en       (sram_weight_write_enable),
      .wr_addr     (sram_weight_write_address),
      .wr_data     (sram_weight_write_data),
      .last        (w_w_last),
      .ovf         (w_w_ovf)
   );

   assign s.s_ready = w_s_ready;
   assign dut_valid = r_dut_valid;
   assign job_done  = r_job_done;
   assign job_busy  = r_job_busy;
   assign job_err   = r_job_err;
endmodule
`default_nettype wire

// File: tb/tb_attn_job_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_attn_job_loader: scoreboard bench with a compute-block model   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_attn_job_loader;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        dut_ready;
   logic        job_busy, job_done, job_err, dut_valid;
   logic        in_we, w_we;
   logic [15:0] in_addr, w_addr;
   logic [31:0] in_data, w_data;

   attn_job_loader_if #(.DATA_W(32)) s_if ();

   attn_job_loader #(.ADDR_W(16), .DATA_W(32), .NUM_WMAT(3)) dut (
      .clk                       (clk),
      .reset                     (reset),
      .s                         (s_if),
      .job_busy                  (job_busy),
      .job_done                  (job_done),
      .job_err                   (job_err),
      .dut_valid                 (dut_valid),
      .dut_ready                 (dut_ready),
      .sram_input_write_enable   (in_we),
      .sram_input_write_address  (in_addr),
      .sram_input_write_data     (in_data),
      .sram_weight_write_enable  (w_we),
      .sram_weight_write_address (w_addr),
      .sram_weight_write_data    (w_data)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [47:0] in_q[$];
   logic [47:0] w_q[$];
   int          dv_cnt = 0;
   int          done_cnt = 0;
   logic [15:0] last_in_addr = '0;
   logic        hold_low = 1'b0;
   int          busy_cycles = 3;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every SRAM write must follow an accept and match the queue head
   initial begin
      logic last_acc;
      logic [47:0] e;
      last_acc = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            last_acc = 1'b0;
         end else begin
            if (in_we) begin
               check("in_write_follows_accept", last_acc, 1'b1);
               if (in_q.size() == 0) check("in_write_unexpected", {in_addr, in_data}, 48'h0);
               else begin
                  e = in_q.pop_front();
                  check("in_write", {in_addr, in_data}, e);
               end
               last_in_addr = in_addr;
            end
            if (w_we) begin
               check("w_write_follows_accept", last_acc, 1'b1);
               if (w_q.size() == 0) check("w_write_unexpected", {w_addr, w_data}, 48'h0);
               else begin
                  e = w_q.pop_front();
                  check("w_write", {w_addr, w_data}, e);
               end
            end
            if (dut_valid) dv_cnt++;
            if (job_done) done_cnt++;
            last_acc = s_if.s_valid && s_if.s_ready;
         end
      end
   end

   // Compute-block model: drops ready on dut_valid, stays busy busy_cycles cycles
   initial begin
      dut_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (reset) dut_ready = 1'b1;
         else if (hold_low) dut_ready = 1'b0;
         else if (dut_valid) begin
            dut_ready = 1'b0;
            @(negedge clk);
            check("dut_valid_one_cycle", dut_valid, 1'b0);
            repeat (busy_cycles - 1) @(negedge clk);
            check("no_early_done_busy", {job_done, job_busy}, 2'b01);
            dut_ready = 1'b1;
            @(negedge clk);
            check("done_after_ready", {job_done, job_busy}, 2'b10);
            @(negedge clk);
            check("done_one_cycle", job_done, 1'b0);
         end else dut_ready = 1'b1;
      end
   end

   task automatic finish_now();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "bench aborted");
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accepting edge
   task automatic send(input logic [31:0] d, input int gap);
      logic acc;
      int   waitc;
      if (gap > 0) begin
         s_if.s_valid = 1'b0;
         repeat (gap) @(posedge clk);
         #1;
      end
      s_if.s_valid = 1'b1;
      s_if.s_data  = d;
      waitc = 0;
      forever begin
         @(negedge clk);
         acc = s_if.s_ready;
         @(posedge clk);
         #1;
         if (acc) break;
         waitc++;
         if (waitc > 200) begin
            n_err++;
            $display("FAIL send_timeout: got no s_ready expected accept of %h", d);
            finish_now();
         end
      end
   endtask

   task automatic wait_done(input int target, input int budget);
      int c;
      c = 0;
      while (done_cnt < target && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("job_done_seen", (done_cnt >= target), 1'b1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outs(input string name);
      check(name, {s_if.s_ready, job_busy, job_done, job_err, dut_valid, in_we, w_we,
                   in_addr, w_addr, in_data, w_data}, {1'b1, 6'b0, 96'h0});
   endtask

   task automatic run_job(input logic [31:0] hdr_in, input int n_in, input logic [31:0] hdr_w,
                          input int n_w, input int gap, input int busy, input logic hold,
                          input logic exp_err);
      int d0, v0;
      logic [31:0] d;
      d0 = done_cnt;
      v0 = dv_cnt;
      busy_cycles = busy;
      hold_low = hold;
      send(hdr_in, gap);
      in_q.push_back({16'h0, hdr_in});
      check("busy_after_hdr", job_busy, 1'b1);
      check("err_after_hdr", job_err, exp_err);
      for (int k = 1; k <= n_in; k++) begin
         d = 32'hA000_0000 + 32'(k);
         send(d, gap);
         if (k <= 65535) in_q.push_back({16'(k), d});
      end
      send(hdr_w, gap);
      w_q.push_back({16'h0, hdr_w});
      for (int k = 1; k <= n_w; k++) begin
         d = 32'hB000_0000 + 32'(k);
         send(d, gap);
         w_q.push_back({16'(k), d});
      end
      s_if.s_valid = 1'b0;
      if (hold) begin
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("held_kick", {dut_valid, s_if.s_ready, job_busy}, 3'b001);
         end
         hold_low = 1'b0;
      end else begin
         @(negedge clk);
         check("kick_entry_no_valid", {dut_valid, s_if.s_ready}, 2'b00);
         @(negedge clk);
         check("kick_valid_next_cycle", dut_valid, 1'b1);
      end
      wait_done(d0 + 1, busy + 100);
      check("one_dut_valid_pulse", dv_cnt - v0, 1);
      check("in_queue_drained", in_q.size(), 0);
      check("w_queue_drained", w_q.size(), 0);
      check("err_sticky", job_err, exp_err);
      check("idle_after_done", {s_if.s_ready, job_busy}, 2'b10);
   endtask

   initial begin
      int d0;
      s_if.s_valid = 1'b0;
      s_if.s_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outs("reset_values");
      reset = 1'b0;
      @(posedge clk);
      #1;

      // 2x3 input, 3x2 weights (3*6 = 18 elements), back-to-back words
      run_job(32'h0002_0003, 6, 32'h0003_0002, 18, 0, 3, 1'b0, 1'b0);
      // same job with s_valid toggling every other cycle
      run_job(32'h0002_0003, 6, 32'h0003_0002, 18, 1, 3, 1'b0, 1'b0);
      // compute block busy for 50 cycles
      run_job(32'h0002_0003, 6, 32'h0003_0002, 18, 0, 50, 1'b0, 1'b0);
      // dut_ready low when KICK is entered
      run_job(32'h0001_0004, 4, 32'h0002_0001, 6, 0, 2, 1'b1, 1'b0);
      // 256x256 = 65536 elements overflows a 16-bit address space
      run_job(32'h0100_0100, 65536, 32'h0000_0000, 0, 0, 2, 1'b0, 1'b1);
      check("last_in_addr_ffff", last_in_addr, 16'hFFFF);
      // next input header clears job_err
      run_job(32'h0001_0001, 1, 32'h0001_0001, 3, 0, 1, 1'b0, 1'b0);

      // reset during W_DATA
      d0 = done_cnt;
      send(32'h0002_0003, 0);
      in_q.push_back({16'h0, 32'h0002_0003});
      for (int k = 1; k <= 6; k++) begin
         send(32'hC000_0000 + 32'(k), 0);
         in_q.push_back({16'(k), 32'hC000_0000 + 32'(k)});
      end
      send(32'h0003_0002, 0);
      w_q.push_back({16'h0, 32'h0003_0002});
      for (int k = 1; k <= 5; k++) begin
         send(32'hD000_0000 + 32'(k), 0);
         w_q.push_back({16'(k), 32'hD000_0000 + 32'(k)});
      end
      s_if.s_valid = 1'b0;
      #2 reset = 1'b1;
      #1 check_reset_outs("async_reset_mid_job");
      in_q.delete();
      w_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("no_done_after_reset", done_cnt, d0);
      check("dut_valid_after_reset", dut_valid, 1'b0);
      run_job(32'h0002_0003, 6, 32'h0003_0002, 18, 0, 4, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
